// File: rtl/seg7_display_driver_pkg.sv
// seg7_pkg: shared constants, FSM encoding and digit-to-segment encoding for the
// 3-digit common-anode display driver.
package seg7_pkg;
  localparam int NUM_DIGITS = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef logic [3:0] bcd_t;
  // Active-low segments {g,f,e,d,c,b,a}; non-decimal nibbles show nothing
  function automatic logic [6:0] seg7_encode(input bcd_t d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg7_display_driver_if.sv
// seg7_if: value input plus converted/display outputs of the display driver.
interface seg7_if;
  import seg7_pkg::*;
  logic [7:0]              value_in;
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic                    busy;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  modport master(output value_in, input bcd_out, busy, an_n, seg_n);
  modport slave(input value_in, output bcd_out, busy, an_n, seg_n);
endinterface

// File: rtl/seg7_display_driver_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one shift per clock, 10 cycles per accepted value.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bin_in,
  output logic [11:0] bcd_out,
  output logic        busy
);
  logic [1:0]  state;
  logic [19:0] sh, adj;
  logic [2:0]  cnt;
  logic [7:0]  samp, last_val;
  always_comb begin
    adj = sh;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[8+4*i +: 4] = sh[8+4*i +: 4] >= 4'd5 ? sh[8+4*i +: 4] + 4'd3 : sh[8+4*i +: 4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      sh       <= '0;
      cnt      <= '0;
      samp     <= '0;
      last_val <= '0;
      bcd_out  <= '0;
    end else
      case (state)
        ST_IDLE: if (bin_in != last_val) begin
          sh    <= {12'b0, bin_in};
          samp  <= bin_in;
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sh  <= {adj[18:0], 1'b0};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= ST_DONE;
        end
        default: begin
          bcd_out  <= sh[19:8];
          last_val <= samp;
          state    <= ST_IDLE;
        end
      endcase
  assign busy = state != ST_IDLE;
endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: converts the counter value to BCD and scans it onto a
// time-multiplexed common-anode 3-digit 7-segment display.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  seg7_if.slave bus
);
  logic [15:0]           div_cnt;
  logic [1:0]            digit_idx;
  bcd_t                  hun, ten, one, digit;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_nxt;
  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bus.value_in),
    .bcd_out (bus.bcd_out),
    .busy    (bus.busy)
  );
  assign {hun, ten, one} = bus.bcd_out;
  always_comb begin
    digit  = digit_idx == 2'd2 ? hun : digit_idx == 2'd1 ? ten : one;
    blank  = BLANK_LZ && hun == 4'd0 && (digit_idx == 2'd2 || (digit_idx == 2'd1 && ten == 4'd0));
    an_nxt = ~(NUM_DIGITS'(1) << digit_idx);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
      bus.an_n  <= 3'b110;
      bus.seg_n <= 7'h40;
    end else begin
      div_cnt <= div_cnt == 16'(REFRESH_DIV - 1) ? '0 : div_cnt + 16'd1;
      if (div_cnt == 16'(REFRESH_DIV - 1))
        digit_idx <= digit_idx == 2'(NUM_DIGITS - 1) ? '0 : digit_idx + 2'd1;
      bus.an_n  <= an_nxt;
      bus.seg_n <= blank ? SEG_BLANK : seg7_encode(digit);
    end
endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: scoreboard bench; two instances (leading-zero blanking on/off)
// share clock, reset and stimulus.
module tb_seg7_display_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0, errors = 0, cyc = 0;
  logic [11:0] exp_q[$], obs_q[$];
  int obs_t[$];
  logic [11:0] prev_bcd = '0;

  seg7_if bus1();
  seg7_if bus0();
  seg7_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  seg7_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst_n) prev_bcd = '0;
    else if (bus1.bcd_out !== prev_bcd) begin
      obs_q.push_back(bus1.bcd_out);
      obs_t.push_back(cyc);
      prev_bcd = bus1.bcd_out;
    end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input logic [11:0] b, input int idx, input bit blz);
    logic [3:0] d;
    d = idx == 2 ? b[11:8] : idx == 1 ? b[7:4] : b[3:0];
    if (blz && b[11:8] == 4'd0 && (idx == 2 || (idx == 1 && b[7:4] == 4'd0))) return 7'h7F;
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int an_idx(input logic [2:0] an);
    return an === 3'b110 ? 0 : an === 3'b101 ? 1 : an === 3'b011 ? 2 : -1;
  endfunction

  task automatic test_reset();
    int idx;
    logic [2:0] ea;
    #2 rst_n = 1'b0;
    repeat (3) step();
    vectors++; if (bus1.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bus1.bcd_out); end
    vectors++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus1.busy); end
    vectors++; if (bus1.an_n !== 3'b110) begin errors++; $display("FAIL reset_an got %b want 110", bus1.an_n); end
    vectors++; if (bus1.seg_n !== 7'h40) begin errors++; $display("FAIL reset_seg got %h want 40", bus1.seg_n); end
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      idx = ((e - 1) / 4) % 3;
      ea = idx == 0 ? 3'b110 : idx == 1 ? 3'b101 : 3'b011;
      vectors++; if (bus1.an_n !== ea) begin errors++; $display("FAIL scan_an edge %0d got %b want %b", e, bus1.an_n, ea); end
      vectors++; if (bus1.seg_n !== ref_seg(12'h000, idx, 1'b1)) begin errors++; $display("FAIL scan_seg_blz1 edge %0d got %h want %h", e, bus1.seg_n, ref_seg(12'h000, idx, 1'b1)); end
      vectors++; if (bus0.seg_n !== ref_seg(12'h000, idx, 1'b0)) begin errors++; $display("FAIL scan_seg_blz0 edge %0d got %h want %h", e, bus0.seg_n, ref_seg(12'h000, idx, 1'b0)); end
      vectors++; if (bus1.busy !== 1'b0 || bus1.bcd_out !== 12'h000) begin errors++; $display("FAIL idle_zero edge %0d busy %b bcd %h want 0/000", e, bus1.busy, bus1.bcd_out); end
    end
    vectors++; if (obs_q.size() !== 0) begin errors++; $display("FAIL idle_zero_conv got %0d updates want 0", obs_q.size()); end
  endtask

  task automatic test_convert(input logic [7:0] v, input string name);
    int t0, nb, t, idx, mask;
    logic [11:0] e, o;
    bus1.value_in = v;
    bus0.value_in = v;
    exp_q.push_back(ref_bcd(int'(v)));
    t0 = cyc;
    nb = 0;
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) begin step(); nb += int'(bus1.busy); end
    vectors++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL %s timeout no bcd_out update want %h", name, exp_q[0]);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front(); o = obs_q.pop_front(); t = obs_t.pop_front();
    if (o !== e) begin errors++; $display("FAIL %s bcd got %h want %h", name, o, e); end
    vectors++; if (t - t0 !== 10) begin errors++; $display("FAIL %s latency got %0d want 10", name, t - t0); end
    vectors++; if (nb !== 9) begin errors++; $display("FAIL %s busy_cycles got %0d want 9", name, nb); end
    vectors++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, bus1.busy); end
    vectors++; if (bus0.bcd_out !== e) begin errors++; $display("FAIL %s bcd_blz0 got %h want %h", name, bus0.bcd_out, e); end
    step();
    mask = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      idx = an_idx(bus1.an_n);
      vectors++;
      if (idx < 0) begin errors++; $display("FAIL %s an_onehot got %b", name, bus1.an_n); end
      else begin
        mask |= 1 << idx;
        vectors++; if (bus1.seg_n !== ref_seg(e, idx, 1'b1)) begin errors++; $display("FAIL %s seg_blz1 digit %0d got %h want %h", name, idx, bus1.seg_n, ref_seg(e, idx, 1'b1)); end
        vectors++; if (bus0.seg_n !== ref_seg(e, idx, 1'b0)) begin errors++; $display("FAIL %s seg_blz0 digit %0d got %h want %h", name, idx, bus0.seg_n, ref_seg(e, idx, 1'b0)); end
      end
    end
    vectors++; if (mask !== 7) begin errors++; $display("FAIL %s scan_coverage got %b want 111", name, mask); end
  endtask

  task automatic test_skip();
    int t0, t;
    logic [11:0] e, o;
    bus1.value_in = 8'd100; bus0.value_in = 8'd100;
    exp_q.push_back(ref_bcd(100));
    t0 = cyc;
    repeat (3) step();
    vectors++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL skip_busy got %b want 1", bus1.busy); end
    bus1.value_in = 8'd101; bus0.value_in = 8'd101;
    exp_q.push_back(ref_bcd(101));
    for (int i = 0; i < 40 && obs_q.size() < 2; i++) step();
    repeat (12) step();
    vectors++; if (obs_q.size() !== 2) begin errors++; $display("FAIL skip_count got %0d want 2", obs_q.size()); end
    for (int n = 1; obs_q.size() > 0 && exp_q.size() > 0; n++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = obs_t.pop_front();
      vectors++; if (o !== e) begin errors++; $display("FAIL skip_val%0d got %h want %h", n, o, e); end
      vectors++; if (t - t0 !== 10 * n) begin errors++; $display("FAIL skip_time%0d got %0d want %0d", n, t - t0, 10 * n); end
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_back_to_back();
    int t0, t, n;
    logic [11:0] e, o;
    t0 = cyc;
    for (int i = 0; i < 50; i++) begin
      bus1.value_in = 8'(150 + i); bus0.value_in = 8'(150 + i);
      if (i % 10 == 0) exp_q.push_back(ref_bcd(150 + i));
      step();
    end
    exp_q.push_back(ref_bcd(199));
    for (int i = 0; i < 40 && obs_q.size() < exp_q.size(); i++) step();
    vectors++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = obs_t.pop_front();
      vectors++; if (o !== e) begin errors++; $display("FAIL b2b_val%0d got %h want %h", n, o, e); end
      vectors++; if (t - t0 !== 10 * n + 10) begin errors++; $display("FAIL b2b_time%0d got %0d want %0d", n, t - t0, 10 * n + 10); end
      n++;
    end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    bus1.value_in = 8'd42; bus0.value_in = 8'd42;
    repeat (3) step();
    vectors++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus1.busy); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus1.busy); end
    vectors++; if (bus1.bcd_out !== 12'h000) begin errors++; $display("FAIL mid_bcd got %h want 000", bus1.bcd_out); end
    vectors++; if (bus1.an_n !== 3'b110) begin errors++; $display("FAIL mid_an got %b want 110", bus1.an_n); end
    vectors++; if (bus1.seg_n !== 7'h40 || bus0.seg_n !== 7'h40) begin errors++; $display("FAIL mid_seg got %h/%h want 40/40", bus1.seg_n, bus0.seg_n); end
    exp_q.delete(); obs_q.delete(); obs_t.delete();
    step();
    rst_n = 1'b1;
    test_convert(8'd42, "after_reset42");
  endtask

  initial begin
    bus1.value_in = 8'd0;
    bus0.value_in = 8'd0;
    test_reset();
    test_convert(8'd255, "conv255");
    test_convert(8'd7, "conv7");
    test_convert(8'd0, "conv0");
    test_convert(8'd90, "conv90");
    test_skip();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
